// File: rtl/vending_pkg.sv
// Shared definitions for the vending controller: state encoding, coin unit and
// default coin values / product prices.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  localparam int UNIT_VALUE    = 50;
  localparam int DEF_COIN0_VAL = 1;
  localparam int DEF_COIN1_VAL = 2;
  localparam int DEF_PRICE0    = 4;
  localparam int DEF_PRICE1    = 3;

endpackage

// File: rtl/vending_ctrl_btn_pulse.sv
// Rising-edge one-shot for one raw button level; trig is registered and lasts
// exactly one cycle per press.
module btn_pulse (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic trig
);

  logic prev;

  // History resets to "pressed" so a button held through reset must be
  // released before it can fire again.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b1;
      trig <= 1'b0;
    end else begin
      prev <= btn;
      trig <= btn & ~prev;
    end
  end

endmodule

// File: rtl/vending_ctrl.sv
// Vending controller: coin credit accumulation, priced product sale, change
// return and cancel refund, driven by one-shot button triggers.
module vending_ctrl
  import vending_pkg::*;
#(
  parameter int CW         = 4,
  parameter int MAX_CREDIT = 7,
  parameter int N_COIN     = 2,
  parameter int COIN0_VAL  = DEF_COIN0_VAL,
  parameter int COIN1_VAL  = DEF_COIN1_VAL,
  parameter int N_PROD     = 2,
  parameter int PRICE0     = DEF_PRICE0,
  parameter int PRICE1     = DEF_PRICE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_COIN-1:0] coin,
  input  logic [N_PROD-1:0] sel,
  input  logic              cancel,
  output logic [CW-1:0]     credit,
  output logic [1:0]        state,
  output logic [N_PROD-1:0] vend,
  output logic              chg_pulse,
  output logic              coin_rej,
  output logic              busy
);

  function automatic logic [CW:0] coin_value(input int i);
    return (i == 0) ? (CW+1)'(COIN0_VAL) : (CW+1)'(COIN1_VAL);
  endfunction

  function automatic logic [CW:0] price_value(input int i);
    return (i == 0) ? (CW+1)'(PRICE0) : (CW+1)'(PRICE1);
  endfunction

  logic [N_COIN-1:0] coin_t, coin_pick;
  logic [N_PROD-1:0] sel_t, sel_pick;
  logic              cancel_t;

  for (genvar gi = 0; gi < N_COIN; gi++) begin : g_coin
    btn_pulse u_coin (.clk(clk), .rst(rst), .btn(coin[gi]), .trig(coin_t[gi]));
  end
  for (genvar gi = 0; gi < N_PROD; gi++) begin : g_sel
    btn_pulse u_sel (.clk(clk), .rst(rst), .btn(sel[gi]), .trig(sel_t[gi]));
  end
  btn_pulse u_cancel (.clk(clk), .rst(rst), .btn(cancel), .trig(cancel_t));

  state_t              state_q, state_d;
  logic [CW-1:0]       credit_q, credit_d;
  logic [N_PROD-1:0]   vend_q, vend_d;
  logic                chg_q, chg_d, rej_q, rej_d, busy_q;
  logic [CW:0]         coin_val_sel, price_sel, sum;

  // Lowest-index trigger wins; values are muxed from the one-hot pick.
  always_comb begin
    coin_pick    = coin_t & (~coin_t + N_COIN'(1));
    sel_pick     = sel_t & (~sel_t + N_PROD'(1));
    coin_val_sel = '0;
    price_sel    = '0;
    for (int i = 0; i < N_COIN; i++)
      if (coin_pick[i]) coin_val_sel = coin_value(i);
    for (int i = 0; i < N_PROD; i++)
      if (sel_pick[i]) price_sel = price_value(i);
    sum = {1'b0, credit_q} + coin_val_sel;
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    vend_d   = '0;
    chg_d    = 1'b0;
    rej_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cancel_t) begin
          rej_d = |coin_t;
          if (credit_q != '0) begin
            state_d  = CHANGE;
            chg_d    = 1'b1;
            credit_d = credit_q - CW'(1);
          end
        end else if (|sel_t) begin
          rej_d = |coin_t;
          if ({1'b0, credit_q} >= price_sel) begin
            credit_d = credit_q - price_sel[CW-1:0];
            vend_d   = sel_pick;
            state_d  = VEND;
          end
        end else if (|coin_t) begin
          rej_d = |(coin_t & ~coin_pick);
          if (sum <= (CW+1)'(MAX_CREDIT)) credit_d = sum[CW-1:0];
          else                            rej_d    = 1'b1;
        end
      end
      VEND: begin
        rej_d = |coin_t;
        if (credit_q != '0) begin
          state_d  = CHANGE;
          chg_d    = 1'b1;
          credit_d = credit_q - CW'(1);
        end else begin
          state_d = IDLE;
        end
      end
      CHANGE: begin
        // Pulse on alternate cycles; leave after the gap following the last pulse
        // would begin, i.e. on the edge after credit reaches zero.
        rej_d = |coin_t;
        if (chg_q) begin
          if (credit_q == '0) state_d = IDLE;
        end else begin
          chg_d    = 1'b1;
          credit_d = credit_q - CW'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        credit_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      vend_q   <= '0;
      chg_q    <= 1'b0;
      rej_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      vend_q   <= vend_d;
      chg_q    <= chg_d;
      rej_q    <= rej_d;
      busy_q   <= (state_d == VEND) || (state_d == CHANGE);
    end
  end

  assign credit    = credit_q;
  assign state     = state_q;
  assign vend      = vend_q;
  assign chg_pulse = chg_q;
  assign coin_rej  = rej_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vending_ctrl.sv
// Bench for vending_ctrl: expected output pulses queued as stimulus is applied,
// popped by a negedge monitor; credit/state checked at known cycles.
module tb_vending_ctrl;

  localparam int CW = 4;
  localparam int EV_VEND = 100, EV_REJ = 200, EV_CHG = 300;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    coin = '0;
  logic [1:0]    sel = '0;
  logic          cancel = 1'b0;
  logic [CW-1:0] credit;
  logic [1:0]    state;
  logic [1:0]    vend;
  logic          chg_pulse, coin_rej, busy;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  logic prev_chg = 1'b0;

  vending_ctrl dut (
    .clk(clk), .rst(rst), .coin(coin), .sel(sel), .cancel(cancel),
    .credit(credit), .state(state), .vend(vend), .chg_pulse(chg_pulse),
    .coin_rej(coin_rej), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int pop_exp();
    if (exp_q.size() == 0) return -1;
    return exp_q.pop_front();
  endfunction

  // Every output pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (vend !== 2'b00 && vend !== 2'bxx) chk("vend_evt", EV_VEND + int'(vend), pop_exp());
    if (coin_rej === 1'b1) chk("rej_evt", EV_REJ, pop_exp());
    if (chg_pulse === 1'b1) begin
      chk("chg_evt", EV_CHG, pop_exp());
      chk("chg_alt", int'(prev_chg), 0);
    end
    prev_chg = (chg_pulse === 1'b1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [1:0] c, input logic [1:0] s, input logic k);
    @(negedge clk);
    coin = c; sel = s; cancel = k;
    @(negedge clk);
    coin = '0; sel = '0; cancel = 1'b0;
  endtask

  task automatic push_chg(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(EV_CHG);
  endtask

  initial begin
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);
    chk("rst_credit", int'(credit), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_vend", int'(vend), 0);
    chk("rst_chg", int'(chg_pulse), 0);
    chk("rst_rej", int'(coin_rej), 0);
    chk("rst_busy", int'(busy), 0);

    // exact payment
    press(2'b10, 2'b00, 1'b0); wait_cyc(1);
    chk("exact_c2", int'(credit), 2);
    press(2'b10, 2'b00, 1'b0); wait_cyc(1);
    chk("exact_c4", int'(credit), 4);
    exp_q.push_back(EV_VEND + 1);
    press(2'b00, 2'b01, 1'b0); wait_cyc(1);
    chk("exact_vstate", int'(state), 1);
    chk("exact_vcredit", int'(credit), 0);
    chk("exact_busy", int'(busy), 1);
    wait_cyc(1);
    chk("exact_idle", int'(state), 0);
    chk("exact_q", exp_q.size(), 0);

    // sale with change of 3
    for (int i = 0; i < 3; i++) press(2'b10, 2'b00, 1'b0);
    wait_cyc(1);
    chk("chg_c6", int'(credit), 6);
    exp_q.push_back(EV_VEND + 2);
    push_chg(3);
    press(2'b00, 2'b10, 1'b0); wait_cyc(1);
    chk("chg_vstate", int'(state), 1);
    chk("chg_vcredit", int'(credit), 3);
    wait_cyc(1);
    chk("chg_c1_state", int'(state), 2);
    chk("chg_c1_credit", int'(credit), 2);
    wait_cyc(4);
    chk("chg_c5_state", int'(state), 2);
    chk("chg_c5_credit", int'(credit), 0);
    wait_cyc(1);
    chk("chg_idle", int'(state), 0);
    chk("chg_busy", int'(busy), 0);
    chk("chg_q", exp_q.size(), 0);

    // overflow reject at credit 6, then refund
    for (int i = 0; i < 3; i++) press(2'b10, 2'b00, 1'b0);
    exp_q.push_back(EV_REJ);
    press(2'b10, 2'b00, 1'b0); wait_cyc(1);
    chk("ovf_credit", int'(credit), 6);
    push_chg(6);
    press(2'b00, 2'b00, 1'b1); wait_cyc(12);
    chk("ovf_ref_state", int'(state), 0);
    chk("ovf_ref_credit", int'(credit), 0);
    chk("ovf_q", exp_q.size(), 0);

    // insufficient credit
    press(2'b10, 2'b00, 1'b0);
    press(2'b00, 2'b01, 1'b0); wait_cyc(1);
    chk("insuf_credit", int'(credit), 2);
    chk("insuf_state", int'(state), 0);

    // two coins at once: lowest taken, other rejected
    exp_q.push_back(EV_REJ);
    press(2'b11, 2'b00, 1'b0); wait_cyc(1);
    chk("dual_credit", int'(credit), 3);
    press(2'b10, 2'b00, 1'b0); wait_cyc(1);
    chk("dual_c5", int'(credit), 5);

    // cancel beats sel: full refund, no vend
    push_chg(5);
    press(2'b00, 2'b01, 1'b1); wait_cyc(1);
    chk("csel_state", int'(state), 2);
    chk("csel_credit", int'(credit), 4);
    wait_cyc(9);
    chk("csel_idle", int'(state), 0);
    chk("csel_zero", int'(credit), 0);
    chk("csel_q", exp_q.size(), 0);

    // held coin counts once
    @(negedge clk); coin = 2'b01;
    wait_cyc(10);
    coin = 2'b00;
    wait_cyc(1);
    chk("hold_credit", int'(credit), 1);

    // reset in the middle of a 3-unit refund, coin held through reset
    press(2'b10, 2'b00, 1'b0); wait_cyc(1);
    chk("rr_c3", int'(credit), 3);
    push_chg(1);
    press(2'b00, 2'b00, 1'b1); wait_cyc(1);
    chk("rr_pulse1", int'(chg_pulse), 1);
    rst = 1'b1; coin = 2'b01;
    wait_cyc(1);
    chk("rr_state", int'(state), 0);
    chk("rr_credit", int'(credit), 0);
    chk("rr_chg", int'(chg_pulse), 0);
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(6);
    chk("rr_held_credit", int'(credit), 0);
    coin = 2'b00;
    wait_cyc(3);
    chk("rr_end_credit", int'(credit), 0);
    chk("rr_end_state", int'(state), 0);
    chk("rr_q", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vending_ctrl.md
# vending_ctrl

Parametrised vending-machine controller, successor to the fixed three-button, single-price machine. It accumulates coin credit from N_COIN debounced coin buttons and sells one of N_PROD products, each with its own price. After a sale it returns the remaining credit as change, and a cancel button refunds the full credit. It sits between the board's button/edge logic and the dispense/change actuators, and reports credit and state for the display.

## Interface
Parameters:
- CW, default 4: credit register width in coin units.
- MAX_CREDIT, default 7: highest credit accepted, in units. Must be ≤ 2^CW−1.
- N_COIN, default 2: number of coin inputs.
- COIN0_VAL, default 1: value of coin[0] in units (one unit = 50).
- COIN1_VAL, default 2: value of coin[1] in units.
- N_PROD, default 2: number of products.
- PRICE0, default 4: price of product 0 in units.
- PRICE1, default 3: price of product 1 in units.

Ports:
- clk, in, 1: system clock, rising-edge.
- rst, in, 1: synchronous reset, active-high.
- coin, in, N_COIN: raw level coin buttons.
- sel, in, N_PROD: raw level product-select buttons.
- cancel, in, 1: raw level refund button.
- credit, out, CW: current credit in units. Reset value 0.
- state, out, 2: FSM state. Reset value IDLE.
- vend, out, N_PROD: one-cycle dispense pulse per product. Reset value 0.
- chg_pulse, out, 1: one-cycle pulse for each unit of change returned. Reset value 0.
- coin_rej, out, 1: one-cycle pulse when an inserted coin is refused. Reset value 0.
- busy, out, 1: high in VEND and CHANGE. Reset value 0.

## Operation
- Every raw input passes through a rising-edge one-shot. The one-shot gives one trigger per press, however long the button is held.
- The FSM has three states, encoded in the shared package: IDLE=0, VEND=1, CHANGE=2. Code 3 is illegal and goes to IDLE with credit cleared.
- IDLE, priority order:
  - cancel > sel > coin. Triggers of lower priority in the same cycle are dropped; a dropped coin trigger pulses coin_rej.
  - cancel with credit > 0 goes to CHANGE. Cancel with credit = 0 does nothing.
  - sel: the lowest-index asserted trigger is chosen. If credit ≥ PRICEi: credit ← credit − PRICEi, vend[i] pulses, go to VEND. If credit < PRICEi, the press is ignored and the state stays IDLE.
  - coin: the lowest-index trigger is taken. If credit + value ≤ MAX_CREDIT, it is added. Otherwise credit is unchanged and coin_rej pulses. Any other coin triggers in the same cycle also pulse coin_rej.
- VEND lasts one cycle. Go to CHANGE if credit > 0, else IDLE.
- CHANGE:
  - chg_pulse is high on alternate cycles: high, low, high…
  - credit decrements by 1 with each pulse.
  - Go to IDLE on the cycle after the pulse that brings credit to 0.
- In VEND and CHANGE, sel and cancel triggers are ignored and coin triggers pulse coin_rej.
- Arithmetic: compute credit + value at CW+1 bits, so no wrap-around occurs before the MAX_CREDIT compare. Subtraction never underflows, because of the guards above.
- rst asserted at any point, including mid-CHANGE, returns to IDLE and clears credit and all outputs. Undelivered change is forfeited. One-shot history also clears, so a button held through reset does not trigger.

## Timing
- One-shot latency: a button first sampled high at edge N raises its trigger during cycle N..N+1. Its effect on credit, state, vend and coin_rej is visible after edge N+1.
- All outputs are registered. vend, chg_pulse and coin_rej are exactly one cycle wide.
- A sale leaving change R takes:
  - 1 VEND cycle, then
  - 2R−1 CHANGE cycles carrying R pulses, then
  - IDLE on the following edge.

## Structure
- Package vending_pkg: state encoding constants, unit value (50), default coin values and prices.
- Sub-module btn_pulse: per-input synchronous rising-edge one-shot. It has ports clk, rst, btn, trig and is instantiated N_COIN + N_PROD + 1 times.
- Top level contains the FSM, the credit datapath and the coin/product priority encoders.

## Test plan
Defaults throughout: COIN0=1, COIN1=2, PRICE0=4, PRICE1=3, MAX_CREDIT=7.
- Exact payment: press coin[1] twice, then sel[0]. Credit goes 2 → 4; vend[0] pulses; credit returns to 0; no chg_pulse.
- Change: press coin[1] ×3 (credit 6), then sel[1]. vend[1] pulses, credit = 3, then three chg_pulse pulses on alternate cycles, then IDLE with credit 0.
- Overflow and insufficient credit:
  - With credit 6, press coin[1]: coin_rej pulses, credit stays 6.
  - With credit 2, press sel[0]: ignored, credit 2, no vend.
- Simultaneous and held inputs:
  - coin[0] and coin[1] in the same cycle: credit +1 and coin_rej pulses.
  - cancel and sel[0] together with credit 5: refund of 5 chg_pulse pulses, no vend.
  - Holding coin[0] for 10 cycles adds only 1.
- Reset mid-CHANGE: assert rst after the 1st chg_pulse of a 3-unit refund. On the next cycle state = IDLE, credit = 0, no further pulses. A coin held through reset does not add credit.
